maq_bcd: RTL and testbench

MAQ_BCD -- requirements
Module: maq_bcd

---
 rtl/maq_bcd.sv | 135 +++++++++++++
 tb/tb_maq_bcd.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/maq_bcd.sv
// BCD modulo counter stage (e.g. hours/minutes of a clock) with up/down/load control
// and an optional 12-hour display view of the internal 24h-style count.
module maq_bcd #(
  parameter int MAX_VAL = 23,
  parameter int DEZ_W   = 3,
  parameter bit HAS_12H = 1'b1
) (
  input  logic             maqb_clock,
  input  logic             maqb_reset,
  input  logic             maqb_enable,
  input  logic             maqb_inc,
  input  logic             maqb_dec,
  input  logic             maqb_load,
  input  logic [3:0]       maqb_load_uni,
  input  logic [DEZ_W-1:0] maqb_load_dez,
  input  logic             maqb_mode12,
  output logic [3:0]       maqb_uni,
  output logic [DEZ_W-1:0] maqb_dez,
  output logic             maqb_pm,
  output logic             maqb_carry,
  output logic             maqb_borrow,
  output logic             maqb_load_err
);

  localparam logic [3:0]       MAX_UNI = 4'(MAX_VAL % 10);
  localparam logic [DEZ_W-1:0] MAX_DEZ = DEZ_W'(MAX_VAL / 10);

  logic [3:0]       uni_q, uni_d;
  logic [DEZ_W-1:0] dez_q, dez_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             load_err_q, load_err_d;

  logic [10:0] load_val;
  logic        load_ok;
  logic        at_max;
  logic        at_zero;

  assign load_val = 11'(maqb_load_dez) * 11'd10 + 11'(maqb_load_uni);
  assign load_ok  = (maqb_load_uni <= 4'd9) && (load_val <= 11'(MAX_VAL));
  assign at_max   = (uni_q == MAX_UNI) && (dez_q == MAX_DEZ);
  assign at_zero  = (uni_q == 4'd0) && (dez_q == '0);

  // Pulses default low every cycle so each lasts exactly one cycle after its cause.
  always_comb begin
    uni_d      = uni_q;
    dez_d      = dez_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (maqb_enable) begin
      if (maqb_load) begin
        if (load_ok) begin
          uni_d = maqb_load_uni;
          dez_d = maqb_load_dez;
        end else begin
          load_err_d = 1'b1;
        end
      end else if (maqb_inc && !maqb_dec) begin
        if (at_max) begin
          uni_d   = 4'd0;
          dez_d   = '0;
          carry_d = 1'b1;
        end else if (uni_q == 4'd9) begin
          uni_d = 4'd0;
          dez_d = dez_q + DEZ_W'(1);
        end else begin
          uni_d = uni_q + 4'd1;
        end
      end else if (maqb_dec && !maqb_inc) begin
        if (at_zero) begin
          uni_d    = MAX_UNI;
          dez_d    = MAX_DEZ;
          borrow_d = 1'b1;
        end else if (uni_q == 4'd0) begin
          uni_d = 4'd9;
          dez_d = dez_q - DEZ_W'(1);
        end else begin
          uni_d = uni_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge maqb_clock) begin
    if (!maqb_reset) begin
      uni_q      <= 4'd0;
      dez_q      <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      uni_q      <= uni_d;
      dez_q      <= dez_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  logic [6:0] val;
  logic [6:0] hour;

  assign val = 7'(dez_q) * 7'd10 + 7'(uni_q);

  // 12h view maps 0 -> 12 AM and 12 -> 12 PM; the stored count stays 24h-style.
  always_comb begin
    maqb_uni = uni_q;
    maqb_dez = dez_q;
    maqb_pm  = 1'b0;
    hour     = 7'd0;
    if (HAS_12H && maqb_mode12) begin
      if (val == 7'd0) begin
        hour = 7'd12;
      end else if (val <= 7'd12) begin
        hour = val;
      end else begin
        hour = val - 7'd12;
      end
      maqb_pm = (val >= 7'd12);
      if (hour >= 7'd10) begin
        maqb_dez = DEZ_W'(1);
        maqb_uni = 4'(hour - 7'd10);
      end else begin
        maqb_dez = '0;
        maqb_uni = 4'(hour);
      end
    end
  end

  assign maqb_carry    = carry_q;
  assign maqb_borrow   = borrow_q;
  assign maqb_load_err = load_err_q;

endmodule

// File: tb/tb_maq_bcd.sv
// Directed bench for maq_bcd: a default 23/12h instance and a 59/24h-only instance
// share stimulus, each gated by its own enable.
module tb_maq_bcd;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rstN, enA, enB, inc, dec, load, mode12;
   logic [3:0] ldUni;
   logic [2:0] ldDez;

   logic [3:0] aUni, bUni;
   logic [2:0] aDez, bDez;
   logic aPm, aCarry, aBorrow, aErr;
   logic bPm, bCarry, bBorrow, bErr;

   int total = 0;
   int bad = 0;

   maq_bcd dutA (
      .maqb_clock(clock), .maqb_reset(rstN), .maqb_enable(enA),
      .maqb_inc(inc), .maqb_dec(dec), .maqb_load(load),
      .maqb_load_uni(ldUni), .maqb_load_dez(ldDez), .maqb_mode12(mode12),
      .maqb_uni(aUni), .maqb_dez(aDez), .maqb_pm(aPm),
      .maqb_carry(aCarry), .maqb_borrow(aBorrow), .maqb_load_err(aErr)
   );

   maq_bcd #(.MAX_VAL(59), .DEZ_W(3), .HAS_12H(1'b0)) dutB (
      .maqb_clock(clock), .maqb_reset(rstN), .maqb_enable(enB),
      .maqb_inc(inc), .maqb_dec(dec), .maqb_load(load),
      .maqb_load_uni(ldUni), .maqb_load_dez(ldDez), .maqb_mode12(mode12),
      .maqb_uni(bUni), .maqb_dez(bDez), .maqb_pm(bPm),
      .maqb_carry(bCarry), .maqb_borrow(bBorrow), .maqb_load_err(bErr)
   );

   // Packs {uni,dez,pm,carry,borrow,err} so one comparison covers all outputs.
   function automatic int pack(input int u, input int d, input int p,
                               input int c, input int b, input int e);
      return (u << 7) | (d << 4) | (p << 3) | (c << 2) | (b << 1) | e;
   endfunction

   function automatic int obsA();
      return pack(aUni, aDez, aPm, aCarry, aBorrow, aErr);
   endfunction

   function automatic int obsB();
      return pack(bUni, bDez, bPm, bCarry, bBorrow, bErr);
   endfunction

   // Every comparison goes through here so the counters stay consistent.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s got=0x%0h want=0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of control inputs, then samples 1ns after the edge.
   task automatic applyStimulus(input logic i, input logic d, input logic l,
                                input int u, input int z);
      inc   = i;
      dec   = d;
      load  = l;
      ldUni = 4'(u);
      ldDez = 3'(z);
      @(posedge clock);
      #1;
      inc  = 1'b0;
      dec  = 1'b0;
      load = 1'b0;
   endtask

   initial begin
      int h, carries;
      rstN = 1'b0; enA = 1'b1; enB = 1'b0; mode12 = 1'b0;
      inc = 1'b0; dec = 1'b0; load = 1'b0; ldUni = '0; ldDez = '0;

      // Reset overrides a simultaneous increment.
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
      checkOutput("reset24", obsA(), pack(0, 0, 0, 0, 0, 0));
      checkOutput("resetB", obsB(), pack(0, 0, 0, 0, 0, 0));
      mode12 = 1'b1; #1;
      checkOutput("reset12", obsA(), pack(2, 1, 0, 0, 0, 0));
      mode12 = 1'b0; #1;
      rstN = 1'b1;

      // Wrap up and down at the limits.
      applyStimulus(1'b0, 1'b0, 1'b1, 3, 2);
      checkOutput("load23", obsA(), pack(3, 2, 0, 0, 0, 0));
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
      checkOutput("incWrap", obsA(), pack(0, 0, 0, 1, 0, 0));
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
      checkOutput("carryClear", obsA(), pack(0, 0, 0, 0, 0, 0));
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
      checkOutput("decWrap", obsA(), pack(3, 2, 0, 0, 1, 0));
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
      checkOutput("borrowClear", obsA(), pack(3, 2, 0, 0, 0, 0));
      applyStimulus(1'b0, 1'b0, 1'b1, 0, 1);
      checkOutput("load10", obsA(), pack(0, 1, 0, 0, 0, 0));
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
      checkOutput("dec10to9", obsA(), pack(9, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
      checkOutput("inc9to10", obsA(), pack(0, 1, 0, 0, 0, 0));

      // Load acceptance and rejection.
      applyStimulus(1'b0, 1'b0, 1'b1, 5, 1);
      checkOutput("load15", obsA(), pack(5, 1, 0, 0, 0, 0));
      applyStimulus(1'b0, 1'b0, 1'b1, 4, 2);
      checkOutput("load24Rej", obsA(), pack(5, 1, 0, 0, 0, 1));
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
      checkOutput("errClear", obsA(), pack(5, 1, 0, 0, 0, 0));
      applyStimulus(1'b0, 1'b0, 1'b1, 10, 0);
      checkOutput("loadUniA", obsA(), pack(5, 1, 0, 0, 0, 1));
      applyStimulus(1'b1, 1'b0, 1'b1, 0, 2);
      checkOutput("loadBeatsInc", obsA(), pack(0, 2, 0, 0, 0, 0));
      applyStimulus(1'b0, 1'b0, 1'b1, 5, 1);

      // Simultaneous inc/dec holds; disabled block ignores everything.
      applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
      checkOutput("incDecHold", obsA(), pack(5, 1, 0, 0, 0, 0));
      enA = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
      checkOutput("disabledInc", obsA(), pack(5, 1, 0, 0, 0, 0));
      applyStimulus(1'b0, 1'b0, 1'b1, 10, 0);
      checkOutput("disabledLoad", obsA(), pack(5, 1, 0, 0, 0, 0));
      enA = 1'b1;

      // 12-hour sweep with a mode toggle partway through.
      applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
      mode12 = 1'b1; #1;
      checkOutput("sweep0", obsA(), pack(2, 1, 0, 0, 0, 0));
      for (int v = 1; v <= 23; v++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
         h = (v > 12) ? v - 12 : v;
         checkOutput($sformatf("sweep%0d", v), obsA(), pack(h % 10, h / 10, (v >= 12) ? 1 : 0, 0, 0, 0));
         if (v == 14) begin
            mode12 = 1'b0; #1;
            checkOutput("toggle24", obsA(), pack(4, 1, 0, 0, 0, 0));
            mode12 = 1'b1; #1;
            checkOutput("toggle12", obsA(), pack(2, 0, 1, 0, 0, 0));
         end
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
      checkOutput("sweepWrap", obsA(), pack(2, 1, 0, 1, 0, 0));
      mode12 = 1'b0; #1;

      // Reset at the wrap edge suppresses carry.
      applyStimulus(1'b0, 1'b0, 1'b1, 3, 2);
      rstN = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
      checkOutput("resetAtWrap", obsA(), pack(0, 0, 0, 0, 0, 0));
      rstN = 1'b1;

      // MAX_VAL=59 instance, 24h only.
      enA = 1'b0; enB = 1'b1;
      carries = 0;
      for (int i = 1; i <= 60; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
         if (bCarry) carries++;
         if (i == 59) checkOutput("b59", obsB(), pack(9, 5, 0, 0, 0, 0));
      end
      checkOutput("b60Wrap", obsB(), pack(0, 0, 0, 1, 0, 0));
      checkOutput("bCarryCount", carries, 1);
      checkOutput("aUntouched", obsA(), pack(0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
      checkOutput("bIncDecHold", obsB(), pack(0, 0, 0, 0, 0, 0));
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
      checkOutput("bDecWrap", obsB(), pack(9, 5, 0, 0, 1, 0));
      mode12 = 1'b1; #1;
      checkOutput("bMode12Ignored", obsB(), pack(9, 5, 0, 0, 1, 0));
      mode12 = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 0, 6);
      checkOutput("bLoad60Rej", obsB(), pack(9, 5, 0, 0, 0, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
